// File: rtl/cmac_usplus_pkt_emitter_pkg.sv
// cmac_usplus_pkg: shared state enums, length type and saturating-increment helper
package cmac_usplus_pkg;
  typedef enum logic {IDLE, IN_PKT} acc_state_t;
  typedef enum logic [1:0] {K_IDLE, K_WAIT_BUSY, K_WAIT_DONE} kick_state_t;
  typedef logic [13:0] len_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/cmac_usplus_pkt_emitter_if.sv
// cmac_usplus_pkt_emitter_if: packet beat stream in and registered beat stream out
interface cmac_usplus_pkt_emitter_if #(
  parameter int DATA_W = 512,
  parameter int MTY_W  = 8
);
  logic [DATA_W-1:0] din_data;
  logic              din_valid;
  logic              din_sop;
  logic              din_eop;
  logic [MTY_W-1:0]  din_mty;
  logic [DATA_W-1:0] dout_data;
  logic              dout_valid;
  modport master (output din_data, din_valid, din_sop, din_eop, din_mty, input dout_data, dout_valid);
  modport slave (input din_data, din_valid, din_sop, din_eop, din_mty, output dout_data, dout_valid);
endinterface

// File: rtl/cmac_usplus_pkt_emitter_len_fifo_sync.sv
// len_fifo_sync: first-word-fall-through synchronous FIFO for frame lengths
module len_fifo_sync #(
  parameter int W     = 14,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          wr, rd;
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign dout  = mem_q[rd_q];
  assign count = count_q;
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(wr);
      rd_q    <= rd_q + AW'(rd);
      count_q <= count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  // storage needs no reset; occupancy gates what is visible
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/cmac_usplus_pkt_emitter.sv
// cmac_usplus_pkt_emitter: measures frame lengths, queues them and kicks the CMAC per frame
module cmac_usplus_pkt_emitter
  import cmac_usplus_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int MTY_W     = 8,
  parameter int LEN_DEPTH = 16,
  parameter int MAX_BYTES = 9600,
  parameter int TIMEOUT   = 65535
) (
  input  logic                       clk,
  input  logic                       reset_n,
  cmac_usplus_pkt_emitter_if.slave   s,
  output logic                       dout_kick,
  output logic [13:0]                dout_bytes,
  input  logic                       cmac_busy,
  input  logic                       cmac_done,
  output logic [$clog2(LEN_DEPTH):0] pending,
  output logic [15:0]                err_oversize,
  output logic [15:0]                err_orphan,
  output logic [15:0]                err_overflow,
  output logic [15:0]                err_timeout
);
  localparam int BPB = DATA_W / 8;
  localparam int CW  = $clog2(LEN_DEPTH) + 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic [MTY_W-1:0]  mty;
  logic [15:0]       mty_c, beat, sum, nxt_len, acc_q, acc_d;
  logic [16:0]       add;
  logic              accept, orphan, done;
  acc_state_t        ast_q, ast_d;
  logic              push_q;
  len_t              len_q, head, bytes_q, bytes_d;
  logic              full, empty, pop, tmo, tmo_ev, kick_q, kick_d;
  logic [CW-1:0]     count, pending_q;
  kick_state_t       kst_q, kst_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [15:0]       os_q, or_q, ov_q, to_q;
  assign mty     = s.din_mty;
  assign mty_c   = (32'(mty) >= BPB) ? 16'(BPB - 1) : 16'(mty);
  assign beat    = s.din_eop ? 16'(BPB) - mty_c : 16'(BPB);
  assign add     = {1'b0, acc_q} + {1'b0, beat};
  assign sum     = add[16] ? 16'hFFFF : add[15:0];
  assign nxt_len = s.din_sop ? beat : sum;
  assign tmo     = wait_q == TW'(TIMEOUT - 1);
  // frame accumulator: a sop always restarts, beats outside a frame are orphans
  always_comb begin
    accept = s.din_valid && (s.din_sop || ast_q == IN_PKT);
    orphan = s.din_valid && ((ast_q == IDLE) ^ s.din_sop);
    done   = accept && s.din_eop;
    ast_d  = accept ? (s.din_eop ? IDLE : IN_PKT) : ast_q;
    acc_d  = accept ? nxt_len : acc_q;
  end
  // kick handshake with the CMAC, guarded by a per-state wait counter
  always_comb begin
    kst_d   = kst_q;
    kick_d  = kick_q;
    bytes_d = bytes_q;
    pop     = 1'b0;
    tmo_ev  = 1'b0;
    case (kst_q)
      K_IDLE: if (!empty) begin
        pop     = 1'b1;
        bytes_d = head;
        kick_d  = 1'b1;
        kst_d   = K_WAIT_BUSY;
      end
      K_WAIT_BUSY: if (cmac_busy || tmo) begin
        kick_d = 1'b0;
        kst_d  = (cmac_busy && !cmac_done) ? K_WAIT_DONE : K_IDLE;
        tmo_ev = !cmac_busy;
      end
      K_WAIT_DONE: if (cmac_done || tmo) begin
        kst_d  = K_IDLE;
        tmo_ev = !cmac_done;
      end
      default: kst_d = K_IDLE;
    endcase
    wait_d = (kst_d != kst_q || kst_q == K_IDLE) ? '0 : wait_q + TW'(1);
  end
  // all resettable state, push pipeline and saturating error counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      ast_q     <= IDLE;
      acc_q     <= '0;
      push_q    <= 1'b0;
      len_q     <= '0;
      kst_q     <= K_IDLE;
      kick_q    <= 1'b0;
      bytes_q   <= '0;
      wait_q    <= '0;
      pending_q <= '0;
      os_q      <= '0;
      or_q      <= '0;
      ov_q      <= '0;
      to_q      <= '0;
    end else begin
      valid_q   <= s.din_valid;
      ast_q     <= ast_d;
      acc_q     <= acc_d;
      push_q    <= done && nxt_len != '0 && nxt_len <= 16'(MAX_BYTES);
      len_q     <= len_t'(nxt_len);
      kst_q     <= kst_d;
      kick_q    <= kick_d;
      bytes_q   <= bytes_d;
      wait_q    <= wait_d;
      pending_q <= count;
      os_q      <= sat_inc(os_q, done && nxt_len > 16'(MAX_BYTES));
      or_q      <= sat_inc(or_q, orphan);
      ov_q      <= sat_inc(ov_q, push_q && full && !pop);
      to_q      <= sat_inc(to_q, tmo_ev);
    end
  end
  // beat stream delay line, deliberately unreset and ungated
  always_ff @(posedge clk) begin
    data_q <= s.din_data;
  end
  len_fifo_sync #(.W($bits(len_t)), .DEPTH(LEN_DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push_q),
    .pop    (pop),
    .din    (len_q),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );
  assign s.dout_data   = data_q;
  assign s.dout_valid  = valid_q;
  assign dout_kick     = kick_q;
  assign dout_bytes    = bytes_q;
  assign pending       = pending_q;
  assign err_oversize  = os_q;
  assign err_orphan    = or_q;
  assign err_overflow  = ov_q;
  assign err_timeout   = to_q;
endmodule

// File: tb/tb_cmac_usplus_pkt_emitter.sv
// tb_cmac_usplus_pkt_emitter: directed scoreboard bench for the packet emitter
module tb_cmac_usplus_pkt_emitter;
  localparam int DW = 512, MW = 8, LD = 4, MAXB = 9600, TMO = 20, BPB = 64;
  logic        clk = 1'b0, reset_n = 1'b0, cmac_busy = 1'b0, cmac_done = 1'b0, auto_ack = 1'b0;
  logic        dout_kick;
  logic [13:0] dout_bytes;
  logic [2:0]  pending;
  logic [15:0] err_oversize, err_orphan, err_overflow, err_timeout;
  int          errors = 0, checks = 0, max_pend = 0;
  logic [13:0] sb [$];
  logic [DW-1:0] p_data;
  logic        p_valid = 1'b0, p_rstn = 1'b0, kick_prev = 1'b0;

  cmac_usplus_pkt_emitter_if #(.DATA_W(DW), .MTY_W(MW)) bus ();

  cmac_usplus_pkt_emitter #(.DATA_W(DW), .MTY_W(MW), .LEN_DEPTH(LD), .MAX_BYTES(MAXB), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .s(bus), .dout_kick(dout_kick), .dout_bytes(dout_bytes),
    .cmac_busy(cmac_busy), .cmac_done(cmac_done), .pending(pending),
    .err_oversize(err_oversize), .err_orphan(err_orphan), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic drive(input logic v, input logic sop, input logic eop, input logic [MW-1:0] mty);
    bus.din_valid = v;
    bus.din_sop   = sop;
    bus.din_eop   = eop;
    bus.din_mty   = mty;
    bus.din_data  = rnd();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    bus.din_valid = 1'b0;
    bus.din_sop   = 1'b0;
    bus.din_eop   = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [MW-1:0] mty, input bit expect_push);
    int len;
    len = n * BPB - (int'(mty) >= BPB ? BPB - 1 : int'(mty));
    for (int i = 0; i < n; i++) drive(1'b1, i == 0, i == n - 1, mty);
    idle_bus();
    if (expect_push && len >= 1 && len <= MAXB) sb.push_back(14'(len));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || dout_kick) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drain_in_time"}, DW'(n < 300), DW'(1));
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_dout_valid"}, DW'(bus.dout_valid), '0);
    chk({tag, "_dout_kick"}, DW'(dout_kick), '0);
    chk({tag, "_dout_bytes"}, DW'(dout_bytes), '0);
    chk({tag, "_pending"}, DW'(pending), '0);
    chk({tag, "_err_oversize"}, DW'(err_oversize), '0);
    chk({tag, "_err_orphan"}, DW'(err_orphan), '0);
    chk({tag, "_err_overflow"}, DW'(err_overflow), '0);
    chk({tag, "_err_timeout"}, DW'(err_timeout), '0);
    @(posedge clk); #1;
  endtask

  // monitor: one-cycle delay line check and kick scoreboard
  always @(negedge clk) begin
    if (p_rstn) begin
      chk("dout_valid_delay", DW'(bus.dout_valid), DW'(p_valid));
      if (p_valid) chk("dout_data_delay", bus.dout_data, p_data);
    end else chk("dout_valid_in_reset", DW'(bus.dout_valid), '0);
    p_data  = bus.din_data;
    p_valid = bus.din_valid;
    p_rstn  = reset_n;
    if (dout_kick && !kick_prev) begin
      chk("kick_was_expected", DW'(sb.size() != 0), DW'(1));
      if (sb.size() != 0) chk("dout_bytes", DW'(dout_bytes), DW'(sb.pop_front()));
    end
    kick_prev = dout_kick;
    if (int'(pending) > max_pend) max_pend = int'(pending);
  end

  // CMAC model: busy the cycle after a kick, done a few cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && dout_kick) begin
        @(posedge clk); #1 cmac_busy = 1'b1;
        @(posedge clk); #1 cmac_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 cmac_done = 1'b1;
        @(posedge clk); #1 cmac_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.din_data = '0;
    bus.din_mty  = '0;
    idle_bus();
    check_zero("reset");
    reset_n  = 1'b1;
    auto_ack = 1'b1;
    send_frame(1, 4, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("single_kick_not_yet", DW'(dout_kick), '0);
    @(negedge clk);
    chk("single_kick", DW'(dout_kick), DW'(1));
    chk("single_bytes", DW'(dout_bytes), DW'(60));
    @(posedge clk); #1;
    drain("single");
    send_frame(3, 10, 1'b1);
    drain("three_beat");
    chk("three_bytes_held", DW'(dout_bytes), DW'(182));
    send_frame(151, 0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("oversize_count", DW'(err_oversize), DW'(1));
    send_frame(2, 0, 1'b1);
    drain("after_oversize");
    send_frame(1, 200, 1'b1);
    drain("mty_clamp");
    chk("clamp_bytes", DW'(dout_bytes), DW'(1));
    chk("clean_orphan", DW'(err_orphan), '0);
    chk("clean_overflow", DW'(err_overflow), '0);
    chk("clean_timeout", DW'(err_timeout), '0);
    drive(1'b1, 1'b0, 1'b1, 0);
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    chk("orphan_idle", DW'(err_orphan), DW'(1));
    drive(1'b1, 1'b1, 1'b0, 0);
    send_frame(3, 5, 1'b1);
    drain("sop_restart");
    chk("orphan_restart", DW'(err_orphan), DW'(2));
    chk("oversize_stable", DW'(err_oversize), DW'(1));
    auto_ack = 1'b0;
    for (int k = 0; k < 6; k++) send_frame(1, 8'(k * 3), k < 5);
    drain("timeout_flood");
    chk("timeout_count", DW'(err_timeout), DW'(5));
    chk("overflow_count", DW'(err_overflow), DW'(1));
    chk("pending_peak", DW'(max_pend), DW'(LD));
    chk("pending_empty", DW'(pending), '0);
    send_frame(1, 0, 1'b1);
    n = 0;
    while (!dout_kick && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("kick_before_reset", DW'(dout_kick), DW'(1));
    cmac_busy = 1'b1;
    @(posedge clk); #1;
    cmac_busy = 1'b0;
    reset_n = 1'b0;
    bus.din_valid = 1'b1;
    bus.din_sop   = 1'b1;
    @(posedge clk);
    check_zero("reset_wait_done");
    idle_bus();
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 0);
    reset_n = 1'b0;
    idle_bus();
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 0);
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    chk("abandon_orphan", DW'(err_orphan), DW'(1));
    chk("abandon_oversize", DW'(err_oversize), '0);
    auto_ack = 1'b1;
    send_frame(2, 7, 1'b1);
    drain("post_reset");
    chk("post_reset_bytes", DW'(dout_bytes), DW'(121));
    chk("post_reset_timeout", DW'(err_timeout), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
